eeprom_i2c_slave: RTL and testbench

EEPROM_I2C_SLAVE -- requirements
Module: eeprom_i2c_slave

---
 rtl/eeprom_pkg.sv | 20 ++
 rtl/eeprom_mem.sv | 25 ++
 rtl/eeprom_i2c_slave.sv | 188 ++++++++++++++++++
 tb/tb_eeprom_i2c_slave.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_pkg.sv
// Shared constants and FSM state encoding for the I2C EEPROM slave and its benches.
package eeprom_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 8;
    localparam logic [3:0]  DEV_ID_DEFAULT = 4'b1010;

    typedef enum logic [3:0] {
        IDLE,
        CTRL,
        CTRL_ACK,
        ADDR,
        ADDR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

endpackage

// File: rtl/eeprom_mem.sv
// 2048x8 EEPROM array: synchronous write, asynchronous read, contents survive reset.
module eeprom_mem
    import eeprom_pkg::*;
#(
    parameter logic [DATA_W-1:0] MEM_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: MEM_INIT};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eeprom_i2c_slave.sv
// I2C slave front-end for a 2 KiB EEPROM: control byte, address byte, then sequential
// writes or reads with 11-bit auto-incrementing address.
module eeprom_i2c_slave
    import eeprom_pkg::*;
#(
    parameter logic [3:0]        DEV_ID   = DEV_ID_DEFAULT,
    parameter logic [DATA_W-1:0] MEM_INIT = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_q, sda_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det, byte_done;

    state_t              state, state_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   shift, shift_n, byte_in, rdata;
    logic [ADDR_W-1:0]   addr, addr_n, wr_addr_n;
    logic                rd, rd_n, ack_ok, ack_ok_n, sda_oe, sda_oe_n;
    logic                busy_n, wr_pulse_n, mem_we;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
    assign byte_in   = {shift[DATA_W-2:0], sda_s};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            addr     <= '0;
            rd       <= 1'b0;
            ack_ok   <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            addr     <= addr_n;
            rd       <= rd_n;
            ack_ok   <= ack_ok_n;
            sda_oe   <= sda_oe_n;
            busy     <= busy_n;
            wr_pulse <= wr_pulse_n;
            wr_addr  <= wr_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        addr_n     = addr;
        rd_n       = rd;
        ack_ok_n   = ack_ok;
        sda_oe_n   = sda_oe;
        busy_n     = busy;
        wr_addr_n  = wr_addr;
        wr_pulse_n = 1'b0;
        mem_we     = 1'b0;

        if (start_det) begin
            state_n   = CTRL;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            if (scl_rise && (state == CTRL || state == ADDR || state == WDATA)) begin
                shift_n   = byte_in;
                bit_cnt_n = bit_cnt + 3'd1;
            end
            unique case (state)
                IDLE: ;
                CTRL: if (byte_done) begin
                    if (byte_in[7:4] == DEV_ID) begin
                        state_n     = CTRL_ACK;
                        addr_n[10:8] = byte_in[3:1];
                        rd_n        = byte_in[0];
                        busy_n      = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                ADDR: if (byte_done) begin
                    addr_n[7:0] = byte_in;
                    state_n     = ADDR_ACK;
                end
                WDATA: if (byte_done) begin
                    mem_we     = 1'b1;
                    wr_pulse_n = 1'b1;
                    wr_addr_n  = addr;
                    state_n    = WDATA_ACK;
                end
                // sda_oe doubles as the ACK phase: first fall starts the ACK, second ends it
                CTRL_ACK, ADDR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else if (state == CTRL_ACK && rd) begin
                        state_n  = RDATA;
                        shift_n  = rdata;
                        sda_oe_n = ~rdata[DATA_W-1];
                    end else begin
                        sda_oe_n = 1'b0;
                        state_n  = (state == CTRL_ACK) ? ADDR : WDATA;
                        if (state == WDATA_ACK) begin
                            addr_n = addr + 11'd1;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            ack_ok_n = 1'b0;
                            state_n  = RDATA_ACK;
                        end else begin
                            shift_n  = {shift[DATA_W-2:0], shift[DATA_W-1]};
                            sda_oe_n = ~shift[DATA_W-2];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_ok_n = 1'b1;
                            addr_n   = addr + 11'd1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    if (scl_fall && ack_ok) begin
                        ack_ok_n = 1'b0;
                        state_n  = RDATA;
                        shift_n  = rdata;
                        sda_oe_n = ~rdata[DATA_W-1];
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    eeprom_mem #(
        .MEM_INIT(MEM_INIT)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(addr),
        .wdata(byte_in),
        .raddr(addr),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Bench for eeprom_i2c_slave: bit-banged I2C master, array reference model, queued scoreboard.
module tb_eeprom_i2c_slave;

    localparam int Q = 50;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        scl_m = 1'b1;
    logic        m_oe  = 1'b0;
    wire         sda;
    logic        busy, wr_pulse;
    logic [10:0] wr_addr;
    int          tests = 0;
    int          fails = 0;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    eeprom_i2c_slave #(
        .DEV_ID  (4'b1010),
        .MEM_INIT(8'hFF)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_m),
        .sda     (sda),
        .busy    (busy),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr)
    );

    typedef struct {
        int          tag;
        logic [10:0] val;
    } sb_t;

    sb_t         exp_q[$];
    sb_t         obs_q[$];
    logic [18:0] exp_wr_q[$];
    logic [7:0]  wdat[$];
    logic [7:0]  ref_mem [2048];
    logic [10:0] ref_ptr;

    function automatic string tname(int t);
        case (t)
            0:       return "ack_bit";
            1:       return "read_byte";
            2:       return "reset_value";
            3:       return "busy";
            4:       return "sda_level";
            default: return "pending_writes";
        endcase
    endfunction

    always @(negedge clk) begin
        sb_t         e;
        sb_t         o;
        logic [18:0] w;
        if (rst && wr_pulse) begin
            tests++;
            if (exp_wr_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got write to %h, required none", wr_addr);
            end else begin
                w = exp_wr_q.pop_front();
                if (wr_addr !== w[18:8] || u_dut.u_mem.mem[wr_addr] !== w[7:0]) begin
                    fails++;
                    $display("FAIL wr_commit: got addr %h data %h, required addr %h data %h",
                             wr_addr, u_dut.u_mem.mem[wr_addr], w[18:8], w[7:0]);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            tests++;
            if (o.val !== e.val) begin
                fails++;
                $display("FAIL %s: got %h, required %h", tname(e.tag), o.val, e.val);
            end
        end
    end

    task automatic chk(int tag, logic [10:0] act, logic [10:0] expv);
        exp_q.push_back('{tag, expv});
        obs_q.push_back('{tag, act});
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; #Q; scl_m = 1'b1; #Q; m_oe = 1'b1; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; #Q; scl_m = 1'b1; #Q; m_oe = 1'b0; #Q;
    endtask

    task automatic put_bit(logic b);
        m_oe = ~b; #Q; scl_m = 1'b1; #(2 * Q); scl_m = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        m_oe = 1'b0; #Q; scl_m = 1'b1; #Q; b = sda; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic put_byte(logic [7:0] d, logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(a);
        chk(0, 11'(a), 11'(exp_ack));
    endtask

    task automatic get_byte(logic [7:0] exp_d, logic ack);
        logic [7:0] d;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        chk(1, 11'(d), 11'(exp_d));
        put_bit(~ack);
    endtask

    task automatic do_write(logic [2:0] pg, logic [7:0] lo);
        i2c_start();
        put_byte({4'hA, pg, 1'b0}, 1'b0);
        chk(3, 11'(busy), 11'd1);
        put_byte(lo, 1'b0);
        ref_ptr = {pg, lo};
        foreach (wdat[i]) begin
            exp_wr_q.push_back({ref_ptr, wdat[i]});
            put_byte(wdat[i], 1'b0);
            ref_mem[ref_ptr] = wdat[i];
            ref_ptr = ref_ptr + 11'd1;
        end
        i2c_stop();
        chk(3, 11'(busy), 11'd0);
    endtask

    // Master ACKs every byte but the last; the address pointer only advances on ACK.
    task automatic read_bytes(int n);
        for (int i = 0; i < n; i++) begin
            get_byte(ref_mem[ref_ptr], i != n - 1);
            if (i != n - 1) ref_ptr = ref_ptr + 11'd1;
        end
        i2c_stop();
    endtask

    task automatic do_rand_read(logic [2:0] pg, logic [7:0] lo, int n);
        i2c_start();
        put_byte({4'hA, pg, 1'b0}, 1'b0);
        put_byte(lo, 1'b0);
        i2c_start();
        put_byte({4'hA, pg, 1'b1}, 1'b0);
        chk(3, 11'(busy), 11'd1);
        ref_ptr = {pg, lo};
        read_bytes(n);
    endtask

    task automatic do_cur_read(logic [2:0] pg, int n);
        i2c_start();
        put_byte({4'hA, pg, 1'b1}, 1'b0);
        ref_ptr[10:8] = pg;
        read_bytes(n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       b;
        int         op;
        int         n;
        logic [2:0] pg;
        logic [7:0] lo;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'hFF;
        ref_ptr = '0;
        #23;
        chk(2, 11'(busy), 11'd0);
        chk(2, 11'(wr_pulse), 11'd0);
        chk(2, wr_addr, 11'd0);
        chk(4, 11'(sda), 11'd1);
        rst = 1'b1;
        #(4 * Q);

        wdat = '{8'h5A};
        do_write(3'd1, 8'h34);
        do_rand_read(3'd1, 8'h34, 1);

        i2c_start();
        put_byte(8'hB0, 1'b1);
        chk(3, 11'(busy), 11'd0);
        i2c_stop();
        wdat = '{8'hC3, 8'h3C};
        do_write(3'd5, 8'h10);
        do_cur_read(3'd5, 1);

        wdat = '{8'h11, 8'h22};
        do_write(3'd7, 8'hFF);
        do_rand_read(3'd7, 8'hFF, 2);

        i2c_start();
        put_byte(8'hA4, 1'b0);
        put_byte(8'h40, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'($urandom));
        i2c_stop();
        chk(3, 11'(busy), 11'd0);
        chk(4, 11'(sda), 11'd1);
        do_rand_read(3'd2, 8'h40, 1);

        // 0x5A = 0101_1010: after five bits the slave is pulling sda low for bit 2
        i2c_start();
        put_byte(8'hA2, 1'b0);
        put_byte(8'h34, 1'b0);
        i2c_start();
        put_byte(8'hA3, 1'b0);
        for (int i = 0; i < 5; i++) get_bit(b);
        chk(4, 11'(sda), 11'd0);
        rst = 1'b0;
        #30;
        chk(4, 11'(sda), 11'd1);
        chk(2, 11'(busy), 11'd0);
        chk(2, wr_addr, 11'd0);
        rst = 1'b1;
        ref_ptr = '0;
        put_byte(8'hA2, 1'b1);
        i2c_stop();
        do_cur_read(3'd1, 1);
        do_rand_read(3'd1, 8'h34, 1);

        for (int k = 0; k < 16; k++) begin
            op = int'($urandom_range(0, 2));
            n  = int'($urandom_range(1, 3));
            pg = 3'($urandom_range(0, 7));
            lo = 8'($urandom);
            if (k % 5 == 4) begin
                pg = 3'd7;
                lo = 8'hFE;
            end
            case (op)
                0: begin
                    wdat.delete();
                    for (int j = 0; j < n; j++) wdat.push_back(8'($urandom));
                    do_write(pg, lo);
                end
                1:       do_rand_read(pg, lo, n);
                default: do_cur_read(pg, n);
            endcase
        end

        #(4 * Q);
        chk(5, 11'(exp_wr_q.size()), 11'd0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
